mux_rr_sched: RTL and testbench
===============================

Name: mux_rr_sched

Overview:
Round-robin scheduler that shares one 8:1 single-bit multiplexer between 8 requesters.
- Arbitrates among 8 request lines and drives the registered 3-bit select plus a one-hot grant.
- Bounds each tenure to MAX_HOLD cycles.
- Presents the selected data bit with a valid flag.
- Sits in front of the 8:1 mux datapath and is the only block that drives its select.

Parameters:
- N, 8, number of requesters / mux inputs (fixed at 8 for this release).
- SEL_W, 3, select width, log2(N).
- MAX_HOLD, 4, maximum consecutive grant cycles per tenure; legal 1..15.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  8  request per requester; level-sensitive; held while service is wanted.
- d  input  8  data bit per requester; d[i] is mux input i.
- sel  output  3  registered mux select; index of the granted requester.
- gnt  output  8  registered one-hot grant; all-zero when idle.
- valid  output  1  registered; high while a grant is active.
- y  output  1  d[sel] when valid; 0 otherwise (combinational from registered sel/valid).

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: sel=0, gnt=0, valid=0, y=0, state=IDLE, hold_cnt=0, last=7.
- Reset precedence: rst overrides everything. Asserting rst mid-grant clears all state at that edge; the grant is dropped with no partial tenure carried over.
- States: IDLE, GRANT.
- Pick rule: scan indices last+1, last+2, ... mod 8; the first requester with req set wins. Index 0 therefore has priority after reset.
- IDLE:
  - If req==0, stay in IDLE.
  - Else register winner into sel/gnt, set valid=1, hold_cnt=0, go to GRANT.
  - Latency: req seen at edge t gives gnt/valid at t+1.
- GRANT, each edge:
  - release = (req[sel]==0) OR (hold_cnt==MAX_HOLD-1).
  - No release: hold_cnt++; sel/gnt unchanged.
  - On release: last=sel; re-pick in the same cycle with the updated pointer.
    - Winner exists: new sel/gnt at the next edge, valid stays 1, hold_cnt=0. There are no idle bubbles between tenures.
    - No winner: gnt=0, valid=0, go to IDLE.
- A requester whose tenure expired while still requesting gets lowest priority. It is regranted immediately only if it is the sole requester (tenure restarts, hold_cnt=0).
- Dropped request: if req[sel] falls, grant is removed at the next edge; y may show d[sel] for that one cycle.
- MAX_HOLD=1: grant rotates every cycle whenever other requests are pending.
- sel never changes while valid=0 except at grant start; sel holds its last value when idle.
- gnt is always one-hot or zero, and gnt==(valid ? 1<<sel : 0).
- hold_cnt width is 4 bits; it never exceeds MAX_HOLD-1.

Decomposition:
- Package mux_rr_pkg holds:
  - Localparams N=8, SEL_W=3.
  - State enum {IDLE, GRANT}.
  - Helper function onehot(sel).
- One sub-module, rr_pick: combinational rotating priority picker.
  - Inputs: req[7:0], last[2:0].
  - Outputs: any, idx[2:0].
  - Instantiated once; all sequential logic lives in mux_rr_sched.

Test Plan:
1. Reset:
   - Stimulus: rst=1 for 2 cycles with req=8'hFF.
   - Required: gnt=0, sel=0, valid=0, y=0 throughout.
   - After release: gnt=8'h01 one cycle after the first sampled edge.
2. Full contention, MAX_HOLD=4:
   - Stimulus: req=8'hFF held, d=8'hA5.
   - Required: sel walks 0..7 with 4 cycles each, then wraps to 0.
   - y follows bit i of 8'hA5 (1,0,1,0,0,1,0,1); valid never drops.
3. Early release:
   - Stimulus: req=8'h0C; drop req[2] after 1 granted cycle.
   - Required: sel=2 for 2 cycles, then sel=3 immediately with no valid gap.
   - When req[3] drops, valid=0 and state returns to IDLE.
4. Sole requester expiry:
   - Stimulus: req=8'h20 held for 10 cycles, MAX_HOLD=4.
   - Required: sel=5 and valid=1 continuously; hold_cnt restarts every 4 cycles.
5. Fairness after expiry:
   - Stimulus: req=8'h81, grant on 7 expires.
   - Required: next grant is 0, then 7; never 7 twice in a row while req[0]=1.
6. Reset mid-grant:
   - Stimulus: assert rst during cycle 2 of a sel=3 tenure.
   - Required: gnt=0 and valid=0 at that edge.
   - After release with req=8'h08: priority restarts from index 0, so sel=3 is granted again at edge+1.

Source files
------------

// File: rtl/mux_rr_pkg.sv
// mux_rr_pkg: shared definitions for the round-robin mux scheduler.
//   N      : number of requesters / mux inputs
//   SEL_W  : select width, log2(N)
//   state_t: scheduler FSM state encoding
//   onehot : select index -> one-hot grant vector
package mux_rr_pkg;

   localparam int N     = 8;
   localparam int SEL_W = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] s);
      logic [N-1:0] v;
      v    = '0;
      v[s] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority picker.
//   req  [N-1:0]     : request vector
//   last [SEL_W-1:0] : most recently serviced index (lowest priority)
//   any              : at least one request is set
//   idx  [SEL_W-1:0] : winning index, first set request scanning last+1, last+2, ...
module rr_pick
   import mux_rr_pkg::*;
(
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] last,
   output logic             any,
   output logic [SEL_W-1:0] idx
);

   logic [SEL_W-1:0] cand;

   // Walk from the farthest candidate (last itself) to the nearest (last+1)
   // so the nearest set request is the one left standing in idx.
   always_comb begin
      any  = 1'b0;
      idx  = '0;
      cand = '0;
      for (int i = N; i >= 1; i--) begin
         cand = last + SEL_W'(i);
         if (req[cand]) begin
            any = 1'b1;
            idx = cand;
         end
      end
   end

endmodule

// File: rtl/mux_rr_sched.sv
// mux_rr_sched: round-robin scheduler driving the select of an 8:1 single-bit mux.
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   req      : level-sensitive request per requester
//   d        : data bit per requester (mux inputs)
//   sel      : registered mux select (index of granted requester)
//   gnt      : registered one-hot grant, zero when idle
//   valid    : registered, high while a grant is active
//   y        : d[sel] while valid, else 0
//   state    : FSM state (debug visibility)
//   hold_cnt : cycles already spent in the current tenure (debug visibility)
//
// Handshake: req[i] is held high for as long as requester i wants service;
// the requester owns the mux on every cycle where gnt[i]/valid are high, and
// loses it at the edge after it drops req[i] or after MAX_HOLD granted cycles.
module mux_rr_sched
   import mux_rr_pkg::*;
#(
   parameter int MAX_HOLD = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   input  logic [N-1:0]     d,
   output logic [SEL_W-1:0] sel,
   output logic [N-1:0]     gnt,
   output logic             valid,
   output logic             y,
   output state_t           state,
   output logic [3:0]       hold_cnt
);

   localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

   logic [SEL_W-1:0] last;
   logic [SEL_W-1:0] pick_last;
   logic             pick_any;
   logic [SEL_W-1:0] pick_idx;
   logic             rel;

   state_t           state_n;
   logic [3:0]       hold_n;
   logic [SEL_W-1:0] last_n;
   logic [SEL_W-1:0] sel_n;
   logic [N-1:0]     gnt_n;
   logic             valid_n;

   // On release the outgoing holder becomes the pointer immediately, so the
   // re-pick in the same cycle already treats it as lowest priority.
   always_comb begin
      rel       = (state == GRANT) && (!req[sel] || (hold_cnt == HOLD_LAST));
      pick_last = rel ? sel : last;
   end

   rr_pick u_pick (
      .req  (req),
      .last (pick_last),
      .any  (pick_any),
      .idx  (pick_idx)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         hold_cnt <= '0;
         last     <= SEL_W'(N - 1);
         sel      <= '0;
         gnt      <= '0;
         valid    <= 1'b0;
      end else begin
         state    <= state_n;
         hold_cnt <= hold_n;
         last     <= last_n;
         sel      <= sel_n;
         gnt      <= gnt_n;
         valid    <= valid_n;
      end
   end

   // Next-state logic
   always_comb begin
      state_n = state;
      hold_n  = hold_cnt;
      last_n  = last;
      sel_n   = sel;
      gnt_n   = gnt;
      valid_n = valid;
      case (state)
         IDLE: begin
            if (pick_any) begin
               state_n = GRANT;
               sel_n   = pick_idx;
               gnt_n   = onehot(pick_idx);
               valid_n = 1'b1;
               hold_n  = '0;
            end
         end
         GRANT: begin
            if (!rel) begin
               hold_n = hold_cnt + 4'd1;
            end else begin
               last_n = sel;
               hold_n = '0;
               if (pick_any) begin
                  sel_n = pick_idx;
                  gnt_n = onehot(pick_idx);
               end else begin
                  // sel keeps its last value while idle
                  state_n = IDLE;
                  gnt_n   = '0;
                  valid_n = 1'b0;
               end
            end
         end
         default: begin
            state_n = IDLE;
            gnt_n   = '0;
            valid_n = 1'b0;
         end
      endcase
   end

   // Output logic
   always_comb begin
      y = valid ? d[sel] : 1'b0;
   end

endmodule

// File: tb/tb_mux_rr_sched.sv
module tb_mux_rr_sched;
   import mux_rr_pkg::*;

   localparam int MH = 4;
   localparam int W  = 18;   // {state, hold[3:0], valid, sel[2:0], gnt[7:0], y}

   // ---------------- clock / reset ----------------
   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     req;
   logic [N-1:0]     d;
   logic [SEL_W-1:0] sel;
   logic [N-1:0]     gnt;
   logic             valid;
   logic             y;
   state_t           state;
   logic [3:0]       hold_cnt;

   always #5 clk = ~clk;

   mux_rr_sched #(.MAX_HOLD(MH)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .d        (d),
      .sel      (sel),
      .gnt      (gnt),
      .valid    (valid),
      .y        (y),
      .state    (state),
      .hold_cnt (hold_cnt)
   );

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   int           pass_cnt  = 0;
   int           check_cnt = 0;

   // reference model state
   logic         m_state;
   logic [3:0]   m_hold;
   logic [2:0]   m_last;
   logic [2:0]   m_sel;
   logic         m_valid;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_cnt++;
      if (obs === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   task automatic model_reset();
      m_state = 1'b0;
      m_hold  = 4'd0;
      m_last  = 3'd7;
      m_sel   = 3'd0;
      m_valid = 1'b0;
   endtask

   function automatic void scan(input logic [7:0] rq, input logic [2:0] lst,
                                output logic found, output logic [2:0] w);
      int c;
      found = 1'b0;
      w     = 3'd0;
      for (int k = 1; k <= 8; k++) begin
         c = (int'(lst) + k) % 8;
         if (!found && rq[c]) begin
            found = 1'b1;
            w     = 3'(c);
         end
      end
   endfunction

   // Advance the model across one rising edge with the given inputs.
   task automatic model_step(input logic r, input logic [7:0] rq);
      logic       f;
      logic [2:0] w;
      if (r) begin
         model_reset();
      end else if (!m_valid) begin
         scan(rq, m_last, f, w);
         if (f) begin
            m_sel = w; m_valid = 1'b1; m_state = 1'b1; m_hold = 4'd0;
         end
      end else if (rq[m_sel] && (int'(m_hold) != MH - 1)) begin
         m_hold = m_hold + 4'd1;
      end else begin
         m_last = m_sel;
         m_hold = 4'd0;
         scan(rq, m_last, f, w);
         if (f) m_sel = w;
         else begin
            m_valid = 1'b0; m_state = 1'b0;
         end
      end
   endtask

   function automatic logic [W-1:0] model_pack(input logic [7:0] dd);
      logic [7:0] g;
      logic       yy;
      g  = m_valid ? (8'h01 << m_sel) : 8'h00;
      yy = m_valid ? dd[m_sel] : 1'b0;
      return {m_state, m_hold, m_valid, m_sel, g, yy};
   endfunction

   task automatic compare_out();
      logic [W-1:0] e;
      if (exp_q.size() == 0) begin
         check_eq("queue_empty", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check_eq("gnt",      gnt,             e[8:1]);
         check_eq("sel",      sel,             e[11:9]);
         check_eq("valid",    valid,           e[12]);
         check_eq("y",        y,               e[0]);
         check_eq("hold_cnt", hold_cnt,        e[16:13]);
         check_eq("state",    32'(state),      e[17]);
      end
   endtask

   // ---------------- driver ----------------
   task automatic drive_cycle(input logic r, input logic [7:0] rq, input logic [7:0] dd);
      @(negedge clk);
      rst = r;
      req = rq;
      d   = dd;
      model_step(r, rq);
      exp_q.push_back(model_pack(dd));
      @(posedge clk);
      #1;
      compare_out();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1;
      req = 8'h00;
      d   = 8'h00;
      model_reset();

      // reset with full request load
      drive_cycle(1'b1, 8'hFF, 8'hA5);
      drive_cycle(1'b1, 8'hFF, 8'hA5);
      check_eq("rst_gnt", gnt, 8'h00);

      // full contention: 4 cycles per index, wrap back to 0
      for (int k = 0; k < 36; k++) begin
         drive_cycle(1'b0, 8'hFF, 8'hA5);
         check_eq("walk_sel", sel, 32'((k / 4) % 8));
         check_eq("walk_valid", valid, 1'b1);
      end

      // early release
      drive_cycle(1'b1, 8'h00, 8'h00);
      drive_cycle(1'b0, 8'h0C, 8'h04);
      check_eq("early_sel2a", sel, 3'd2);
      drive_cycle(1'b0, 8'h0C, 8'h04);
      check_eq("early_sel2b", sel, 3'd2);
      drive_cycle(1'b0, 8'h08, 8'h04);
      check_eq("early_sel3", sel, 3'd3);
      check_eq("early_nogap", valid, 1'b1);
      drive_cycle(1'b0, 8'h08, 8'h08);
      drive_cycle(1'b0, 8'h00, 8'h08);
      check_eq("early_idle", valid, 1'b0);

      // sole requester expiry: continuous service, tenure restarts
      drive_cycle(1'b1, 8'h00, 8'h00);
      for (int k = 0; k < 10; k++) begin
         drive_cycle(1'b0, 8'h20, 8'h20);
         check_eq("sole_sel", sel, 3'd5);
         check_eq("sole_hold", hold_cnt, 32'(k % 4));
      end

      // fairness after expiry: 0 and 7 alternate tenures
      drive_cycle(1'b1, 8'h00, 8'h00);
      for (int k = 0; k < 16; k++) begin
         drive_cycle(1'b0, 8'h81, 8'h80);
         check_eq("fair_sel", sel, ((k / 4) % 2 == 0) ? 32'd0 : 32'd7);
      end

      // reset mid-grant
      drive_cycle(1'b1, 8'h00, 8'h00);
      drive_cycle(1'b0, 8'h08, 8'hFF);
      drive_cycle(1'b0, 8'h08, 8'hFF);
      drive_cycle(1'b1, 8'h08, 8'hFF);
      check_eq("midrst_valid", valid, 1'b0);
      drive_cycle(1'b0, 8'h08, 8'hFF);
      check_eq("midrst_sel", sel, 3'd3);

      // random traffic with sparse requests and occasional reset
      for (int k = 0; k < 400; k++) begin
         logic [7:0] rq;
         rq = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
         drive_cycle(($urandom_range(0, 49) == 0), rq, 8'($urandom_range(0, 255)));
      end

      check_eq("queue_drained", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
